// File: rtl/operand_fetch_if.sv
// Operand-fetch stage port bundle: decode-side issue, register-file read,
// writeback snoop and the execute-side operand packet.
interface operand_fetch_if #(
    parameter int XLEN = 32,
    parameter int IW   = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic            in_uses_rs1;
    logic            in_uses_rs2;
    logic [4:0]      in_rd;
    logic            in_long;
    logic [IW-1:0]   in_instr;

    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic [XLEN-1:0] rf_rv1;
    logic [XLEN-1:0] rf_rv2;

    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_wd;
    logic            wb_long_done;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rv1;
    logic [XLEN-1:0] out_rv2;
    logic [4:0]      out_rd;
    logic [IW-1:0]   out_instr;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2,
        input  in_rd, in_long, in_instr,
        output in_ready,
        output rf_rs1, rf_rs2,
        input  rf_rv1, rf_rv2,
        input  wb_we, wb_rd, wb_wd, wb_long_done,
        output out_valid, out_rv1, out_rv2, out_rd, out_instr,
        input  out_ready
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2,
        output in_rd, in_long, in_instr,
        input  in_ready,
        input  rf_rs1, rf_rs2,
        output rf_rv1, rf_rv2,
        output wb_we, wb_rd, wb_wd, wb_long_done,
        input  out_valid, out_rv1, out_rv2, out_rd, out_instr,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: sync-read RF addressing, writeback bypass, long-latency
// scoreboard and a one-entry valid/ready operand packet towards execute.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int IW   = 32
) (
    input  logic             clk,
    input  logic             reset,
    operand_fetch_if.slave   bus
);
    logic [31:0]     r_pending;
    logic            r_lw_we;
    logic [4:0]      r_lw_rd;
    logic [XLEN-1:0] r_lw_wd;
    logic            r_s1_valid;
    logic            r_first;
    logic [4:0]      r_s1_rs1;
    logic [4:0]      r_s1_rs2;
    logic [4:0]      r_s1_rd;
    logic [IW-1:0]   r_s1_instr;
    logic [XLEN-1:0] r_hold1;
    logic [XLEN-1:0] r_hold2;

    logic            w_hazard;
    logic            w_accept;
    logic            w_stall;
    logic [31:0]     w_pend_nxt;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_byp1;
    logic [XLEN-1:0] w_byp2;

    assign bus.rf_rs1 = bus.in_rs1;
    assign bus.rf_rs2 = bus.in_rs2;

    // A bit cleared this cycle still blocks; the issue retries next cycle.
    assign w_hazard = (bus.in_uses_rs1 & r_pending[bus.in_rs1])
                    | (bus.in_uses_rs2 & r_pending[bus.in_rs2])
                    | (bus.in_long     & r_pending[bus.in_rd]);

    assign bus.in_ready = !reset && !w_hazard
                        && (!r_s1_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_stall      = r_s1_valid && !bus.out_ready;

    assign bus.out_valid = r_s1_valid;
    assign bus.out_rv1   = w_op1;
    assign bus.out_rv2   = w_op2;
    assign bus.out_rd    = r_s1_rd;
    assign bus.out_instr = r_s1_instr;

    // Resolve operands: fresh RF data plus same-edge write in the first
    // cycle, then the hold registers; stalled packets snoop writeback.
    always_comb begin
        w_op1 = r_hold1;
        w_op2 = r_hold2;
        if (r_first) begin
            w_op1 = bus.rf_rv1;
            w_op2 = bus.rf_rv2;
            if (r_lw_we && r_lw_rd != 5'd0 && r_lw_rd == r_s1_rs1)
                w_op1 = r_lw_wd;
            if (r_lw_we && r_lw_rd != 5'd0 && r_lw_rd == r_s1_rs2)
                w_op2 = r_lw_wd;
        end
        if (r_s1_rs1 == 5'd0)
            w_op1 = '0;
        if (r_s1_rs2 == 5'd0)
            w_op2 = '0;
        w_byp1 = w_op1;
        w_byp2 = w_op2;
        if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == r_s1_rs1)
            w_byp1 = bus.wb_wd;
        if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == r_s1_rs2)
            w_byp2 = bus.wb_wd;
    end

    // Scoreboard next state: retire on long writeback, set on long issue.
    always_comb begin
        w_pend_nxt = r_pending;
        if (bus.wb_we && bus.wb_long_done)
            w_pend_nxt[bus.wb_rd] = 1'b0;
        if (w_accept && bus.in_long && bus.in_rd != 5'd0)
            w_pend_nxt[bus.in_rd] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    // Stage state: scoreboard, last write, and the S1 packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_lw_we    <= 1'b0;
            r_lw_rd    <= '0;
            r_lw_wd    <= '0;
            r_s1_valid <= 1'b0;
            r_first    <= 1'b0;
            r_s1_rs1   <= '0;
            r_s1_rs2   <= '0;
            r_s1_rd    <= '0;
            r_s1_instr <= '0;
            r_hold1    <= '0;
            r_hold2    <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_lw_we   <= bus.wb_we;
            r_lw_rd   <= bus.wb_rd;
            r_lw_wd   <= bus.wb_wd;
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_first    <= 1'b1;
                r_s1_rs1   <= bus.in_rs1;
                r_s1_rs2   <= bus.in_rs2;
                r_s1_rd    <= bus.in_rd;
                r_s1_instr <= bus.in_instr;
            end else begin
                r_first <= 1'b0;
                if (w_stall) begin
                    r_hold1 <= w_byp1;
                    r_hold2 <= w_byp2;
                end else begin
                    r_s1_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: RF model, architectural register model
// and an expected-packet queue checked whenever a packet is presented.
module tb_operand_fetch;
    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic [4:0]  rd;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    operand_fetch_if #(.XLEN(32), .IW(32)) bus ();

    operand_fetch #(.XLEN(32), .IW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] regs [32];
    logic [31:0] arch [32];
    exp_t        q [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    int          pre_rd [6] = '{5, 6, 7, 9, 12, 3};
    logic [31:0] pre_v  [6] = '{32'h11, 32'h22, 32'h7777,
                                32'h9999, 32'h1212, 32'h33};

    // Synchronous-read register file, read-before-write on the same edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != 5'd0) begin
            regs[bus.wb_rd] <= bus.wb_wd;
        end
        bus.rf_rv1 <= regs[bus.rf_rs1];
        bus.rf_rv2 <= regs[bus.rf_rs2];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed hang, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd,
                          input logic lng, input logic [31:0] instr);
        bus.in_valid    = v;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_uses_rs1 = u1;
        bus.in_uses_rs2 = u2;
        bus.in_rd       = rd;
        bus.in_long     = lng;
        bus.in_instr    = instr;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd,
                          input logic [31:0] wd, input logic ld);
        bus.wb_we        = we;
        bus.wb_rd        = rd;
        bus.wb_wd        = wd;
        bus.wb_long_done = ld;
    endtask

    task automatic tick(input logic er, input string tag);
        logic acc;
        logic hs;
        logic stall;
        exp_t e;
        #1;
        chk({tag, "/in_ready"}, 32'(bus.in_ready), 32'(er));
        acc   = bus.in_valid && er;
        hs    = (q.size() != 0) && bus.out_ready;
        stall = (q.size() != 0) && !bus.out_ready;
        if (!reset && bus.wb_we && bus.wb_rd != 5'd0) begin
            arch[bus.wb_rd] = bus.wb_wd;
            if (stall && q[0].rs1 == bus.wb_rd) q[0].rv1 = bus.wb_wd;
            if (stall && q[0].rs2 == bus.wb_rd) q[0].rv2 = bus.wb_wd;
        end
        e.rs1   = bus.in_rs1;
        e.rs2   = bus.in_rs2;
        e.u1    = bus.in_uses_rs1;
        e.u2    = bus.in_uses_rs2;
        e.rv1   = arch[bus.in_rs1];
        e.rv2   = arch[bus.in_rs2];
        e.rd    = bus.in_rd;
        e.instr = bus.in_instr;
        @(posedge clk);
        if (reset) begin
            q.delete();
            for (int i = 0; i < 32; i++) arch[i] = '0;
        end else begin
            if (hs) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        chk({tag, "/out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, "/out_rd"}, 32'(bus.out_rd), 32'(q[0].rd));
            chk({tag, "/out_instr"}, bus.out_instr, q[0].instr);
            if (q[0].u1) chk({tag, "/out_rv1"}, bus.out_rv1, q[0].rv1);
            if (q[0].u2) chk({tag, "/out_rv2"}, bus.out_rv2, q[0].rv2);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) arch[i] = '0;
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        set_in(1, 5, 6, 1, 1, 1, 0, 32'hAA);
        set_wb(0, 0, 0, 0);
        tick(0, "rst0");
        tick(0, "rst1");
        chk("rst/out_rv1", bus.out_rv1, 32'h0);
        chk("rst/out_rv2", bus.out_rv2, 32'h0);
        chk("rst/out_rd", 32'(bus.out_rd), 32'h0);
        chk("rst/out_instr", bus.out_instr, 32'h0);

        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            set_wb(1, 5'(pre_rd[i]), pre_v[i], 0);
            tick(1, "pre");
        end
        set_wb(0, 0, 0, 0);

        for (int i = 0; i < 3; i++) begin
            set_in(1, 5, 6, 1, 1, 5'(1 + i), 0, 32'(100 + i));
            tick(1, "b2b");
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "b2b_drain");

        set_in(1, 7, 5, 1, 1, 4, 0, 32'd200);
        set_wb(1, 7, 32'hDEAD, 0);
        tick(1, "byp");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0, 0);
        tick(1, "byp_drain");

        bus.out_ready = 1'b0;
        set_in(1, 5, 9, 1, 1, 8, 0, 32'd300);
        tick(1, "hold_acc");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "hold1");
        set_wb(1, 9, 32'h1234, 0);
        tick(0, "hold2");
        set_wb(0, 0, 0, 0);
        tick(0, "hold3");
        bus.out_ready = 1'b1;
        tick(1, "hold_hs");

        set_in(1, 0, 0, 0, 0, 12, 1, 32'd400);
        tick(1, "raw_long");
        set_in(1, 0, 0, 0, 0, 12, 1, 32'd401);
        tick(0, "waw");
        set_in(1, 12, 0, 1, 0, 13, 0, 32'd402);
        tick(0, "raw_stall1");
        tick(0, "raw_stall2");
        set_wb(1, 12, 32'hBEEF, 1);
        tick(0, "raw_wbcyc");
        set_wb(0, 0, 0, 0);
        tick(1, "raw_go");

        set_in(1, 0, 0, 1, 1, 0, 1, 32'd500);
        tick(1, "x0_a");
        set_in(1, 0, 0, 1, 1, 0, 1, 32'd501);
        tick(1, "x0_b");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "x0_drain");

        bus.out_ready = 1'b0;
        set_in(1, 0, 0, 0, 0, 3, 1, 32'd600);
        tick(1, "rst_long");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(0, "rst_mid");
        reset = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1, 3, 0, 1, 0, 14, 0, 32'd601);
        tick(1, "rst_issue");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between decode and execute. It drives the read addresses of the synchronous-read register file and captures the read data one cycle later. It applies writeback bypass to cover the register file's same-edge read-before-write behaviour, and it keeps a scoreboard that stalls issue on registers still awaiting long-latency results (e.g. qubit measurement writebacks). It presents a valid/ready operand packet to execute.

## Interface
- XLEN, 32, data width of operands and writeback data
- IW, 32, width of the opaque instruction/control word carried alongside operands
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle (combinational)
- in_rs1, in_rs2  in  5 each  source register indices
- in_uses_rs1, in_uses_rs2  in  1 each  source is actually read (gates hazard check)
- in_rd  in  5  destination index
- in_long  in  1  destination is written by a long-latency unit
- in_instr  in  IW  passthrough word
- rf_rs1, rf_rs2  out  5 each  register-file read addresses
- rf_rv1, rf_rv2  in  XLEN each  register-file read data, valid one cycle after address
- wb_we  in  1  writeback strobe (same signals drive the register-file write port)
- wb_rd  in  5  writeback index
- wb_wd  in  XLEN  writeback data
- wb_long_done  in  1  this writeback retires a long-latency destination
- out_valid  out  1  operand packet valid
- out_ready  in  1  execute accepts packet
- out_rv1, out_rv2  out  XLEN each  resolved operands
- out_rd  out  5  destination index
- out_instr  out  IW  passthrough word

## Operation
- Two internal positions. S0 is combinational issue: rf_rs1/rf_rs2 = in_rs1/in_rs2 at all times. S1 is a registered packet holding valid, rd, instr, and a hold register per operand.
- Scoreboard: 32-bit pending mask, bit 0 hardwired 0.
  - Set pending[in_rd] on accept when in_long=1 and in_rd≠0.
  - Clear pending[wb_rd] when wb_we & wb_long_done.
  - Set and clear in the same cycle on the same index cannot occur, because the WAW stall prevents it. If it does occur anyway, set wins.
- hazard = (in_uses_rs1 & pending[in_rs1]) | (in_uses_rs2 & pending[in_rs2]) | (in_long & pending[in_rd]). A pending bit cleared this cycle still stalls; the issue proceeds next cycle and reads the written value.
- in_ready = !reset & !hazard & (!s1_valid | out_ready). Accept = in_valid & in_ready.
- A last-write register records (wb_we, wb_rd, wb_wd) every cycle.
- First S1 cycle operand value:
  - rf_rvN, overridden by the last-write wd when last-write we=1, rd≠0 and rd = the captured rsN.
  - Sources with uses=0 still pass through but are don't-care.
- While S1 is stalled (out_valid & !out_ready), the hold register is updated each cycle from the current operand value, replaced by wb_wd if wb_we, wb_rd≠0 and wb_rd = rsN. Writes seen while waiting are always from older instructions.
- Writes landing on or after the out handshake edge are execute-stage forwarding's responsibility, not this block's.
- Register index 0 always yields 0; bypass never matches rd 0.
- Reset, including mid-operation: S1 is dropped, the pending mask and last-write are cleared, and in_ready=0 during reset.

## Timing
- Reset values: out_valid=0, out_rv1=out_rv2=0, out_rd=0, out_instr=0. in_ready=0 while reset is high.
- Accept at edge N: out_valid=1 in cycle N+1. Latency is 1 cycle.
- Throughput is 1 instruction per cycle when out_ready=1 and there is no hazard.
- out_* are stable while out_valid & !out_ready. Values change only through the bypass update defined above.
- Accept and out handshake in the same cycle: S1 is replaced at the edge with no bubble.
- Combinational paths: out_ready→in_ready, and in_rs*/in_rd/in_long→in_ready via the scoreboard. There is no path from in_* to out_*.

## Test plan
- Back-to-back issue, out_ready=1:
  - Stimulus: x5=0x11, x6=0x22; issue rs1=5, rs2=6 on three consecutive cycles.
  - Required: out_valid on cycles 1–3, rv1=0x11, rv2=0x22 each cycle, in_ready never drops.
- Same-edge bypass:
  - Stimulus: wb x7←0xDEAD in the same cycle as accepting an instruction with rs1=7.
  - Required: out_rv1=0xDEAD, even though the register file returns the old value.
- Stall-hold update:
  - Stimulus: out_ready=0 for 3 cycles with rs2=9; wb x9←0x1234 in the 2nd cycle.
  - Required: out_rv2 changes to 0x1234 the following cycle and is held until the handshake.
- Scoreboard RAW:
  - Stimulus: issue in_long rd=12, then rs1=12. Later, wb x12←0xBEEF with wb_long_done.
  - Required: in_ready=0 until the cycle after the wb. The dependent instruction then issues and out_rv1=0xBEEF.
- Scoreboard WAW and x0:
  - Stimulus: an in_long rd=12 while 12 is pending; a separate issue of in_long rd=0 with rs1=0.
  - Required: the rd=12 issue stalls. The rd=0 issue never stalls and yields out_rv1=0.
- Reset mid-operation:
  - Stimulus: reset asserted with S1 valid and pending[3]=1.
  - Required: the next cycle shows out_valid=0, and issuing rs1=3 is accepted immediately.
